// File: rtl/switch_debounce_pkg.sv
// Shared constants and helpers for the DIP-switch conditioning path.
// The tick prescaler is intended for reuse by other input debouncers.
package switch_debounce_pkg;

  localparam int SW_WIDTH          = 24;
  localparam int SW_TICK_DIV       = 100000;
  localparam int SW_STABLE_SAMPLES = 4;

  typedef enum logic [1:0] {
    HIST_MIXED,
    HIST_ONES,
    HIST_ZEROS
  } hist_kind_e;

  // Classifies the low n bits of a sample history as all ones, all zeros or mixed.
  function automatic hist_kind_e hist_classify(input logic [31:0] hist, input int n);
    logic [31:0] mask;
    mask = (n >= 32) ? '1 : ((32'd1 << n) - 32'd1);
    if ((hist & mask) == mask) return HIST_ONES;
    if ((hist & mask) == 32'd0) return HIST_ZEROS;
    return HIST_MIXED;
  endfunction

endpackage

// File: rtl/switch_debounce_if.sv
// Switch conditioning bus: raw pins and ack in, clean levels and change flags out.
interface switch_debounce_if
  import switch_debounce_pkg::*;
#(
  parameter int WIDTH = SW_WIDTH
);

  logic [WIDTH-1:0] sw_raw;
  logic             ack;
  logic [WIDTH-1:0] sw_clean;
  logic             sw_change;
  logic [WIDTH-1:0] change_mask;

  modport master (
    output sw_raw,
    output ack,
    input  sw_clean,
    input  sw_change,
    input  change_mask
  );

  modport slave (
    input  sw_raw,
    input  ack,
    output sw_clean,
    output sw_change,
    output change_mask
  );

endinterface

// File: rtl/switch_tick_gen.sv
// Free-running prescaler; tick_o is high for the one cycle the count sits at TICK_DIV-1.
module switch_tick_gen
  import switch_debounce_pkg::*;
#(
  parameter int TICK_DIV = SW_TICK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick_o
);

  localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = (count_q == LAST) ? '0 : count_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tick_o = (count_q == LAST);

endmodule

// File: rtl/switch_debounce.sv
// Synchronises and debounces the raw DIP switches, then reports which clean bits changed.
// A bit only moves once STABLE_SAMPLES consecutive tick samples agree on the new level.
module switch_debounce
  import switch_debounce_pkg::*;
#(
  parameter int WIDTH          = SW_WIDTH,
  parameter int TICK_DIV       = SW_TICK_DIV,
  parameter int STABLE_SAMPLES = SW_STABLE_SAMPLES
) (
  input  logic             clk,
  input  logic             rst_n,
  switch_debounce_if.slave bus
);

  logic             tick;
  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;
  logic [WIDTH-1:0] clean_q;
  logic [WIDTH-1:0] clean_d;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] mask_d;
  logic             change_q;

  switch_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick_o(tick)
  );

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic [STABLE_SAMPLES-1:0] hist_q;
      logic [STABLE_SAMPLES-1:0] hist_d;
      logic                      clean_bit_d;

      always_comb begin
        hist_d      = hist_q;
        clean_bit_d = clean_q[gi];
        if (tick) begin
          hist_d = {hist_q[STABLE_SAMPLES-2:0], sync2_q[gi]};
          // Acceptance looks at the history including this tick's sample.
          case (hist_classify(32'(hist_d), STABLE_SAMPLES))
            HIST_ONES:  clean_bit_d = 1'b1;
            HIST_ZEROS: clean_bit_d = 1'b0;
            default:    clean_bit_d = clean_q[gi];
          endcase
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          hist_q <= '0;
        end else begin
          hist_q <= hist_d;
        end
      end

      assign clean_d[gi] = clean_bit_d;
    end
  endgenerate

  // An ack coinciding with a fresh change clears only the older flags.
  always_comb begin
    diff   = clean_d ^ clean_q;
    mask_d = (bus.ack ? '0 : mask_q) | diff;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      clean_q  <= '0;
      mask_q   <= '0;
      change_q <= 1'b0;
    end else begin
      sync1_q  <= bus.sw_raw;
      sync2_q  <= sync1_q;
      clean_q  <= clean_d;
      mask_q   <= mask_d;
      change_q <= |diff;
    end
  end

  assign bus.sw_clean    = clean_q;
  assign bus.sw_change   = change_q;
  assign bus.change_mask = mask_q;

endmodule

// File: tb/tb_switch_debounce.sv
// Bench for switch_debounce: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a run-length reference model.
module tb_switch_debounce;

  localparam int W  = 24;
  localparam int TD = 4;
  localparam int S  = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  switch_debounce_if #(.WIDTH(W)) bus ();

  switch_debounce #(
    .WIDTH         (W),
    .TICK_DIV      (TD),
    .STABLE_SAMPLES(S)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: raw input delayed two samples, tick phase, and per-bit run length
  // of identical tick samples. A level is accepted once its run reaches S samples.
  logic [W-1:0] pipe [$];
  int           m_phase;
  int           m_ticks;
  int           run_len [W];
  logic         run_val [W];
  logic [W-1:0] m_clean;
  logic [W-1:0] m_mask;
  logic         m_change;
  logic [W-1:0] m_s2;
  logic [W-1:0] m_nxt;
  logic [W-1:0] m_diff;

  always @(posedge clk) begin
    if (!rst_n) begin
      pipe.delete();
      pipe.push_back('0);
      pipe.push_back('0);
      m_phase  = 0;
      for (int b = 0; b < W; b++) begin
        run_len[b] = S;
        run_val[b] = 1'b0;
      end
      m_clean  = '0;
      m_mask   = '0;
      m_change = 1'b0;
    end else begin
      m_s2  = pipe[0];
      m_nxt = m_clean;
      if (m_phase == TD - 1) begin
        m_ticks++;
        for (int b = 0; b < W; b++) begin
          if (m_s2[b] == run_val[b]) begin
            if (run_len[b] < S) run_len[b]++;
          end else begin
            run_val[b] = m_s2[b];
            run_len[b] = 1;
          end
          if (run_len[b] >= S) m_nxt[b] = run_val[b];
        end
      end
      m_diff   = m_nxt ^ m_clean;
      m_change = |m_diff;
      m_mask   = (bus.ack ? '0 : m_mask) | m_diff;
      m_clean  = m_nxt;
      void'(pipe.pop_front());
      pipe.push_back(bus.sw_raw);
      m_phase = (m_phase + 1) % TD;
    end
  end

  // True when the coming clock edge is a tick that will accept a 1 on bit b.
  function automatic bit accept_next(input int b);
    int len;
    if (m_phase != TD - 1 || m_clean[b] || !pipe[0][b]) return 1'b0;
    len = (run_val[b] == 1'b1) ? run_len[b] + 1 : 1;
    return len >= S;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int val, input int lo, input int hi);
    total++;
    if (val < lo || val > hi) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, val, lo, hi);
    end
  endtask

  // Watches limit cycles; k is the first cycle bit b reads val (0 if never).
  task automatic watch(input int b, input logic val, input int limit, output int k, output int pulses);
    k = 0;
    pulses = 0;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (bus.sw_change) pulses++;
      if (k == 0 && bus.sw_clean[b] === val) k = i;
    end
  endtask

  always @(negedge clk) begin
    chk("cyc_sw_clean", 64'(bus.sw_clean), 64'(m_clean));
    chk("cyc_sw_change", 64'(bus.sw_change), 64'(m_change));
    chk("cyc_change_mask", 64'(bus.change_mask), 64'(m_mask));
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int pulses;
    int t0;
    bit hit;
    logic [W-1:0] target;

    m_ticks = 0;
    bus.sw_raw = '1;
    bus.ack    = 1'b0;
    rst_n      = 1'b0;

    // Power-up with every switch on.
    repeat (5) begin
      @(negedge clk);
      chk("rst_clean", 64'(bus.sw_clean), 64'h0);
      chk("rst_change", 64'(bus.sw_change), 64'h0);
      chk("rst_mask", 64'(bus.change_mask), 64'h0);
    end
    rst_n = 1'b1;
    watch(0, 1'b1, 20, k, pulses);
    chk_range("powerup_latency", k, 1, 13);
    chk("powerup_clean", 64'(bus.sw_clean), 64'hFFFFFF);
    chk("powerup_pulses", 64'(pulses), 64'd1);
    chk("powerup_mask", 64'(bus.change_mask), 64'hFFFFFF);
    $display("txn powerup: accepted after %0d cycles, pulses=%0d", k, pulses);

    // Restart from all switches off.
    bus.sw_raw = '0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Clean step on bit 3. The first edge after the drive samples the change,
    // so the latency in clocks from that edge is k-1.
    bus.sw_raw[3] = 1'b1;
    watch(3, 1'b1, 20, k, pulses);
    chk_range("step_latency", k - 1, 10, 13);
    chk("step_clean", 64'(bus.sw_clean), 64'h000008);
    chk("step_pulses", 64'(pulses), 64'd1);
    chk("step_mask", 64'(bus.change_mask), 64'h000008);
    $display("txn step: bit3 accepted after %0d clocks", k - 1);

    // Five-clock glitches on bit 0 at every tick phase.
    for (int p = 0; p < TD; p++) begin
      hit = 1'b0;
      for (int i = 0; i < 2 * TD && !hit; i++) begin
        if (m_phase == p) hit = 1'b1;
        else @(negedge clk);
      end
      chk("glitch_phase_found", 64'(hit), 64'd1);
      bus.sw_raw[0] = 1'b1;
      repeat (5) @(negedge clk);
      bus.sw_raw[0] = 1'b0;
      watch(0, 1'b1, 20, k, pulses);
      chk("glitch_seen", 64'(k), 64'd0);
      chk("glitch_pulses", 64'(pulses), 64'd0);
      chk("glitch_clean", 64'(bus.sw_clean), 64'h000008);
      chk("glitch_mask", 64'(bus.change_mask), 64'h000008);
      $display("txn glitch: phase %0d pulses=%0d", p, pulses);
    end

    // Ack in the same cycle bit 5 is accepted.
    bus.sw_raw[5] = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 30 && !hit; i++) begin
      @(negedge clk);
      if (accept_next(5)) hit = 1'b1;
    end
    chk("race_found", 64'(hit), 64'd1);
    bus.ack = 1'b1;
    @(negedge clk);
    bus.ack = 1'b0;
    chk("race_mask", 64'(bus.change_mask), 64'h000020);
    chk("race_clean", 64'(bus.sw_clean), 64'h000028);
    bus.ack = 1'b1;
    @(negedge clk);
    bus.ack = 1'b0;
    chk("lone_ack_mask", 64'(bus.change_mask), 64'h0);
    $display("txn ack_race: mask after lone ack %h", bus.change_mask);

    // Bounce on bit 7, then settle high.
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      bus.sw_raw[7] = ~bus.sw_raw[7];
      repeat (3) begin
        @(negedge clk);
        if (bus.sw_change) pulses++;
      end
    end
    chk("bounce_quiet_pulses", 64'(pulses), 64'd0);
    bus.sw_raw[7] = 1'b1;
    watch(7, 1'b1, 20, k, pulses);
    chk_range("bounce_latency", k - 1, 1, 13);
    chk("bounce_pulses", 64'(pulses), 64'd1);
    chk("bounce_clean", 64'(bus.sw_clean), 64'h0000A8);
    chk("bounce_mask", 64'(bus.change_mask), 64'h000080);
    $display("txn bounce: bit7 accepted after %0d clocks", k - 1);

    // Reset two ticks after raising bit 1.
    bus.sw_raw[1] = 1'b1;
    t0 = m_ticks;
    for (int i = 0; i < 4 * TD && m_ticks < t0 + 2; i++) @(negedge clk);
    chk("midrst_ticks", 64'(m_ticks - t0), 64'd2);
    chk("midrst_pre_clean", 64'(bus.sw_clean[1]), 64'd0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_clean", 64'(bus.sw_clean), 64'h0);
    chk("midrst_mask", 64'(bus.change_mask), 64'h0);
    rst_n = 1'b1;
    watch(1, 1'b1, 20, k, pulses);
    chk_range("midrst_latency", k, 10, 13);
    chk("midrst_pulses", 64'(pulses), 64'd1);
    chk("midrst_final", 64'(bus.sw_clean), 64'h0000AA);
    $display("txn midreset: bit1 accepted %0d cycles after release", k);

    // Randomized: slow target changes, short noise bursts, random acks and resets.
    target = bus.sw_raw;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 15) == 0) target = target ^ W'($urandom & $urandom);
      bus.sw_raw = target ^ (($urandom_range(0, 7) == 0) ? W'($urandom & $urandom & $urandom) : W'(0));
      bus.ack    = ($urandom_range(0, 9) == 0);
      rst_n      = ($urandom_range(0, 499) != 0);
    end
    @(negedge clk);
    rst_n   = 1'b1;
    bus.ack = 1'b0;
    $display("txn random: 3000 cycles, final clean %h", bus.sw_clean);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/switch_debounce.md
Name: switch_debounce

Overview:
- Conditions the 24 raw board DIP switches before they reach switch_driver.
- Synchronises each bit, filters mechanical bounce with a shared sample tick, and presents a clean, stable switch vector.
- sw_clean wires directly to switch_driver's switch input.
- Also flags which bits changed, so polling software or a future interrupt source can detect edits.

Parameters:
- WIDTH, 24, number of switch bits.
- TICK_DIV, 100000, clocks per sample tick (1 ms at 100 MHz); must be >= 2.
- STABLE_SAMPLES, 4, consecutive equal samples required to accept a new level; must be >= 2.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, synchronous active-low reset.
- sw_raw, input, WIDTH, asynchronous raw switch pins.
- ack, input, 1, clears change_mask.
- sw_clean, output, WIDTH, debounced switch levels to switch_driver.
- sw_change, output, 1, one-cycle pulse when any sw_clean bit changes.
- change_mask, output, WIDTH, sticky per-bit changed flags.

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous and active-low, sampled only on the rising edge of clk.
- Reset values: while rst_n=0 at a clk edge, every register clears to 0. This covers sync stages, prescaler, history registers, sw_clean, sw_change and change_mask. Reset asserted mid-operation discards any partial history and any pending tick.
- Synchroniser: a 2-flop chain per bit (sync1, sync2). Only sync2 is used downstream.
- Prescaler:
  - Counter runs 0..TICK_DIV-1 and wraps to 0.
  - tick=1 for exactly the one cycle in which count == TICK_DIV-1.
  - Free-running, with no enable.
- History: per bit, a STABLE_SAMPLES-wide shift register. On a tick edge, next_hist = {hist[STABLE_SAMPLES-2:0], sync2[i]}; otherwise it holds.
- Acceptance, same tick edge, evaluated on next_hist:
  - next_hist all-ones and sw_clean[i]=0: sw_clean[i] <= 1.
  - next_hist all-zeros and sw_clean[i]=1: sw_clean[i] <= 0.
  - Otherwise sw_clean[i] holds. Mixed history never changes the output.
- Change reporting:
  - diff = sw_clean_next ^ sw_clean, computed on every edge.
  - sw_change <= |diff. It is therefore high for exactly the one cycle in which the new sw_clean is first visible, and never for two consecutive cycles.
  - change_mask <= (ack ? 0 : change_mask) | diff.
  - Simultaneous ack and a new change: the new bits survive and older bits are cleared.
  - ack with no pending change clears the mask and is otherwise harmless.
- Latency:
  - A clean level change on sw_raw that is held steady reaches sw_clean between 2+(STABLE_SAMPLES-1)*TICK_DIV and 1+STABLE_SAMPLES*TICK_DIV clocks after the raw edge.
  - Tick phase determines where in that window the change lands.
- Glitch rejection: any excursion on sync2 shorter than (STABLE_SAMPLES-1)*TICK_DIV clocks can never change sw_clean.
- Multiple bits:
  - Bits are fully independent.
  - Several bits may flip on the same tick; this produces one sw_change pulse with several diff bits set.
- Power-up: switches that are already on read as 0 until STABLE_SAMPLES ticks after reset release.

Decomposition:
- Shared package: default constants SW_WIDTH=24, SW_TICK_DIV=100000, SW_STABLE_SAMPLES=4.
- One natural sub-module: switch_tick_gen, the prescaler that emits tick. It is reusable by a future button/key debouncer.
- The per-bit synchroniser and history logic stay inline, as a generate loop.

Test Plan (simulation with TICK_DIV=4, STABLE_SAMPLES=3):
- Reset: hold rst_n=0 for 5 clocks with sw_raw=24'hFFFFFF, then release -> all outputs read 0 during reset. sw_clean=24'hFFFFFF within 13 clocks of release. Exactly one sw_change pulse, and change_mask=24'hFFFFFF.
- Clean step: from all-0, set sw_raw[3]=1 and hold -> sw_clean becomes 24'h000008 no earlier than 10 and no later than 13 clocks after the change. sw_change is high for 1 cycle and change_mask[3]=1.
- Glitch: pulse sw_raw[0] high for 5 clocks, at every tick phase 0..3 -> sw_clean, sw_change and change_mask stay 0.
- Bounce: toggle sw_raw[7] every 3 clocks for 30 clocks, then hold 1 -> sw_clean[7] rises once, within 13 clocks of the final toggle. Exactly one sw_change pulse.
- Ack race: with change_mask=24'h000008, assert ack in the same cycle that bit 5 is accepted -> change_mask=24'h000020 next cycle. A following lone ack gives 0.
- Reset mid-operation: drive rst_n=0 for 1 clock two ticks after raising sw_raw[1] -> sw_clean[1] is still 0 and the history restarts. The bit is accepted 10–13 clocks after reset release.
